// File: rtl/comparator_sort_ctrl.sv
// Buffers up to N bytes, bubble-sorts them ascending through one shared 8-bit magnitude
// comparator (one compare per clock), then drains them over a valid/ready stream.
module comparator_sort_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  input  logic [7:0] i_in_data,
  output logic       o_in_ready,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_out_valid,
  output logic [7:0] o_out_data,
  input  logic       i_out_ready,
  output logic       o_done,
  output logic [7:0] o_swap_cnt
);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  localparam logic [IDX_W:0]   CntMax = (IDX_W + 1)'(N);
  localparam logic [IDX_W:0]   CntOne = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

  state_e           r_state;
  logic [7:0]       r_mem [N];
  logic [IDX_W:0]   r_count;
  logic [IDX_W-1:0] r_j;
  logic [IDX_W-1:0] r_lim;
  logic [IDX_W-1:0] r_rd;
  logic             r_noswap;
  logic [7:0]       r_swap_cnt;
  logic             r_done;

  state_e           w_state_d;
  logic [IDX_W:0]   w_count_d;
  logic [IDX_W-1:0] w_j_d;
  logic [IDX_W-1:0] w_lim_d;
  logic [IDX_W-1:0] w_rd_d;
  logic             w_noswap_d;
  logic [7:0]       w_swap_cnt_d;
  logic             w_done_d;

  logic             w_load_we;
  logic             w_swap_en;
  logic [IDX_W:0]   w_cnt_new;
  logic [IDX_W-1:0] w_j1;
  logic [7:0]       w_cmp_a;
  logic [7:0]       w_cmp_b;
  logic             w_a_great_b;

  // Shared comparator: A is the left entry of the current pair, B the right one.
  assign w_j1        = r_j + IdxOne;
  assign w_cmp_a     = r_mem[r_j];
  assign w_cmp_b     = r_mem[w_j1];
  assign w_a_great_b = (w_cmp_a > w_cmp_b);

  assign o_in_ready  = (r_state == StLoad) && (r_count < CntMax);
  assign o_busy      = (r_state != StLoad);
  assign o_out_valid = (r_state == StDrain);
  assign o_out_data  = o_out_valid ? r_mem[r_rd] : 8'h00;
  assign o_done      = r_done;
  assign o_swap_cnt  = r_swap_cnt;

  assign w_load_we   = i_in_valid && o_in_ready;
  assign w_cnt_new   = w_load_we ? (r_count + CntOne) : r_count;

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_j_d        = r_j;
    w_lim_d      = r_lim;
    w_rd_d       = r_rd;
    w_noswap_d   = r_noswap;
    w_swap_cnt_d = r_swap_cnt;
    w_done_d     = 1'b0;
    w_swap_en    = 1'b0;

    unique case (r_state)
      StLoad: begin
        w_count_d = w_cnt_new;
        // A byte arriving alongside start is already counted in w_cnt_new.
        if (i_start && (w_cnt_new != '0)) begin
          w_swap_cnt_d = 8'h00;
          w_j_d        = '0;
          w_lim_d      = IDX_W'(w_cnt_new - CntOne);
          w_noswap_d   = 1'b1;
          w_state_d    = (w_cnt_new == CntOne) ? StDrain : StSort;
        end
      end

      StSort: begin
        w_swap_en = w_a_great_b;
        if (w_a_great_b) begin
          w_swap_cnt_d = (r_swap_cnt == 8'hFF) ? r_swap_cnt : (r_swap_cnt + 8'd1);
          w_noswap_d   = 1'b0;
        end
        if (r_j == (r_lim - IdxOne)) begin
          if ((r_noswap && !w_a_great_b) || (r_lim == IdxOne)) begin
            w_state_d = StDrain;
          end else begin
            w_lim_d    = r_lim - IdxOne;
            w_j_d      = '0;
            w_noswap_d = 1'b1;
          end
        end else begin
          w_j_d = w_j1;
        end
      end

      StDrain: begin
        if (i_out_ready) begin
          if ({1'b0, r_rd} == (r_count - CntOne)) begin
            w_rd_d    = '0;
            w_count_d = '0;
            w_state_d = StLoad;
            w_done_d  = 1'b1;
          end else begin
            w_rd_d = r_rd + IdxOne;
          end
        end
      end

      default: begin
        w_state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StLoad;
      r_count    <= '0;
      r_j        <= '0;
      r_lim      <= '0;
      r_rd       <= '0;
      r_noswap   <= 1'b1;
      r_swap_cnt <= 8'h00;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_j        <= w_j_d;
      r_lim      <= w_lim_d;
      r_rd       <= w_rd_d;
      r_noswap   <= w_noswap_d;
      r_swap_cnt <= w_swap_cnt_d;
      r_done     <= w_done_d;
    end
  end

  // Storage is never reset; stale contents are unreachable until reloaded.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_swap_en) begin
        r_mem[r_j]  <= w_cmp_b;
        r_mem[w_j1] <= w_cmp_a;
      end else if (w_load_we) begin
        r_mem[r_count[IDX_W-1:0]] <= i_in_data;
      end
    end
  end

endmodule

// File: tb/tb_comparator_sort_ctrl.sv
// Self-checking bench for comparator_sort_ctrl: directed and randomized loads checked
// against a queue-based reference (sorted order, inversion count, pass-by-pass cycle count).
module tb_comparator_sort_ctrl;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       start;
  logic       busy;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       done;
  logic [7:0] swap_cnt;

  int tests = 0;
  int fails = 0;
  bq_t acc;

  comparator_sort_ctrl #(.N(N), .IDX_W(IDX_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_in_ready (in_ready),
    .i_start    (start),
    .o_busy     (busy),
    .o_out_valid(out_valid),
    .o_out_data (out_data),
    .i_out_ready(out_ready),
    .o_done     (done),
    .o_swap_cnt (swap_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bubble sort swaps exactly once per inverted pair.
  function automatic int inversions(input bq_t q);
    int c = 0;
    for (int i = 0; i < q.size(); i++)
      for (int k = i + 1; k < q.size(); k++)
        if (q[i] > q[k]) c++;
    return c;
  endfunction

  function automatic int sort_cycles(input bq_t q);
    int cyc = 0;
    int lim;
    bit sw;
    logic [7:0] t;
    if (q.size() < 2) return 0;
    lim = q.size() - 1;
    forever begin
      sw = 1'b0;
      for (int j = 0; j < lim; j++) begin
        cyc++;
        if (q[j] > q[j+1]) begin
          t = q[j]; q[j] = q[j+1]; q[j+1] = t; sw = 1'b1;
        end
      end
      if (!sw || lim == 1) break;
      lim--;
    end
    return cyc;
  endfunction

  task automatic load(input bq_t vals, input bit merge);
    for (int i = 0; i < vals.size(); i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      start    = merge && (i == vals.size() - 1);
      chk("in_ready_load", in_ready, acc.size() < N);
      if (acc.size() < N) acc.push_back(vals[i]);
      step();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1/0, 2: random ready
  task automatic sort_drain(input int mode);
    bq_t exp_q;
    int n, cyc, k, guard;
    exp_q = acc;
    exp_q.sort();
    n = acc.size();
    cyc = 0;
    while (busy === 1'b1 && out_valid !== 1'b1 && cyc < 300) begin
      chk("in_ready_sort", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      start    = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("sort_cycles", cyc, sort_cycles(acc));
    chk("swap_cnt_drain", swap_cnt, inversions(acc));
    k = 0;
    guard = 0;
    while (k < n && guard < 400) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp_q[k]);
      chk("done_low", done, 0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (guard % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      start    = 1'($urandom_range(0, 1));
      step();
      if (out_ready) k++;
      guard++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    chk("drain_count", k, n);
    chk("done_pulse", done, 1);
    chk("out_valid_end", out_valid, 0);
    chk("busy_end", busy, 0);
    chk("in_ready_end", in_ready, 1);
    chk("out_data_idle", out_data, 0);
    chk("swap_cnt_hold", swap_cnt, inversions(acc));
    step();
    chk("done_once", done, 0);
    acc.delete();
  endtask

  initial begin
    bq_t v;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; start = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_swap_cnt", swap_cnt, 0);
    rst = 1'b0;

    // 1) small unsorted set
    v = '{8'd5, 8'd3, 8'd8, 8'd1};
    load(v, 1'b0); do_start(); sort_drain(0);

    // 2) already sorted full buffer
    v = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load(v, 1'b0); do_start(); sort_drain(0);

    // 3) fully reversed, boundary values
    v = '{8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248};
    load(v, 1'b0); do_start(); sort_drain(0);

    // 4) equal keys with a stalling consumer
    v = '{8'd7, 8'd7, 8'd0};
    load(v, 1'b0); do_start(); sort_drain(1);

    // 5) overflow byte dropped, empty start ignored, single byte with same-cycle start
    v = '{8'd9, 8'd4, 8'd6, 8'd2, 8'd8, 8'd1, 8'd3, 8'd5, 8'd77};
    load(v, 1'b0);
    chk("acc_size_full", acc.size(), N);
    do_start(); sort_drain(2);
    do_start();
    chk("empty_start_busy", busy, 0);
    chk("empty_start_in_ready", in_ready, 1);
    v = '{8'd42};
    load(v, 1'b1); sort_drain(0);

    // 6) reset in the middle of a sort
    v = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    load(v, 1'b0); do_start();
    step(); step(); step();
    chk("mid_sort_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    acc.delete();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_swap_cnt", swap_cnt, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_data", out_data, 0);
    v = '{8'd2, 8'd1};
    load(v, 1'b0); do_start(); sort_drain(0);

    // Randomized loads, narrow value range to force duplicates
    for (int it = 0; it < 12; it++) begin
      int n;
      bit merge;
      n = $urandom_range(1, N);
      merge = 1'($urandom_range(0, 1));
      v.delete();
      for (int i = 0; i < n; i++) v.push_back(8'($urandom_range(0, 15)));
      load(v, merge);
      if (!merge) do_start();
      sort_drain($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
